// File: rtl/rpn_evaluator.sv
// Postfix (RPN) evaluator: walks the token queue for one x and computes f(x) in signed Q format.
// Define RPN_EVALUATOR_SATURATE_EN to clamp arithmetic results instead of wrapping.
module rpn_evaluator #(
  parameter int unsigned INTEGER_PART_WIDTH    = 8,
  parameter int unsigned FRACTIONAL_PART_WIDTH = 8,
  parameter int unsigned NUMBER_WIDTH          = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH,
  parameter int unsigned TOKEN_WIDTH           = NUMBER_WIDTH + 1,
  parameter int unsigned OUTPUT_QUEUE_SIZE     = 64,
  parameter int unsigned STACK_SIZE            = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [NUMBER_WIDTH-1:0]              x,
  input  logic [$clog2(OUTPUT_QUEUE_SIZE):0]   token_count,
  output logic                                 queue_rd_en,
  output logic [$clog2(OUTPUT_QUEUE_SIZE)-1:0] queue_rd_index,
  input  logic [TOKEN_WIDTH-1:0]               queue_rd_data,
  input  logic                                 queue_rd_valid,
  output logic                                 busy,
  output logic                                 done,
  output logic [NUMBER_WIDTH-1:0]              result,
  output logic                                 error,
  output logic [2:0]                           error_code
);

  localparam int unsigned NW = NUMBER_WIDTH;
  localparam int unsigned FW = FRACTIONAL_PART_WIDTH;
  localparam int unsigned QW = NW + FW;
  localparam int unsigned IW = $clog2(OUTPUT_QUEUE_SIZE);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned SW = $clog2(STACK_SIZE) + 1;

  localparam logic [2:0] OpPlus = 3'd0, OpSub = 3'd1, OpMul = 3'd2, OpDiv = 3'd3;
  localparam logic [2:0] OpPow = 3'd4, OpBad5 = 3'd5, OpVar = 3'd6, OpBad7 = 3'd7;

  typedef enum logic [2:0] {
    StIdle, StFetch, StWait, StDispatch, StPush, StExec, StFinish, StError
  } state_e;

  function automatic logic signed [2*NW-1:0] ext(input logic [NW-1:0] v);
    return {{NW{v[NW-1]}}, v};
  endfunction

  // Reduce a wide signed intermediate to NW bits: clamp or wrap.
  function automatic logic [NW-1:0] fit(input logic signed [2*NW-1:0] v);
`ifdef RPN_EVALUATOR_SATURATE_EN
    logic signed [2*NW-1:0] hi, lo;
    hi = {{(NW+1){1'b0}}, {(NW-1){1'b1}}};
    lo = {{(NW+1){1'b1}}, {(NW-1){1'b0}}};
    if (v > hi) return {1'b0, {(NW-1){1'b1}}};
    if (v < lo) return {1'b1, {(NW-1){1'b0}}};
`endif
    return v[NW-1:0];
  endfunction

  function automatic logic [NW-1:0] qmul(input logic [NW-1:0] a, input logic [NW-1:0] b);
    logic signed [2*NW-1:0] p;
    p = ext(a) * ext(b);
    return fit(p >>> FW);
  endfunction

  function automatic logic [NW-1:0] mag(input logic [NW-1:0] v);
    return v[NW-1] ? -v : v;
  endfunction

  state_e          state_q, state_d;
  logic [NW-1:0]   x_q, x_d, a_q, a_d, b_q, b_d, acc_q, acc_d, push_q, push_d;
  logic [NW-1:0]   cnt_q, cnt_d, result_q, result_d;
  logic [CW-1:0]   count_q, count_d, idx_q, idx_d;
  logic [SW-1:0]   sp_q, sp_d;
  logic [NW-1:0]   stack_q [STACK_SIZE];
  logic [NW-1:0]   stack_d [STACK_SIZE];
  logic [TOKEN_WIDTH-1:0] tok_q, tok_d;
  logic [QW-1:0]   quo_q, quo_d, quo_nx;
  logic [NW+1:0]   rem_q, rem_d, rem_sh, dvs;
  logic            busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [2:0]      error_code_q, error_code_d, fail_code, op;
  logic            fail, ge;
  logic [NW-1:0]   top_v, sec_v;
  logic signed [NW-1:0]   pow_n;
  logic signed [2*NW-1:0] quo_s;

  assign op     = tok_q[2:0];
  assign top_v  = stack_q[sp_q[SW-2:0] - (SW-1)'(1)];
  assign sec_v  = stack_q[sp_q[SW-2:0] - (SW-1)'(2)];
  assign pow_n  = $signed(b_q) >>> FW;
  // One restoring-division step: shift next dividend bit in, subtract if it fits.
  assign rem_sh = {rem_q[NW:0], quo_q[QW-1]};
  assign dvs    = {2'b00, mag(b_q)};
  assign ge     = rem_sh >= dvs;
  assign quo_nx = {quo_q[QW-2:0], ge};
  assign quo_s  = {{(2*NW-QW){1'b0}}, quo_nx};

  always_comb begin
    state_d = state_q;  x_d = x_q;  a_d = a_q;  b_d = b_q;  acc_d = acc_q;  push_d = push_q;
    cnt_d = cnt_q;  result_d = result_q;  count_d = count_q;  idx_d = idx_q;  sp_d = sp_q;
    stack_d = stack_q;  tok_d = tok_q;  quo_d = quo_q;  rem_d = rem_q;
    busy_d = busy_q;  done_d = done_q;  error_d = error_q;  error_code_d = error_code_q;
    fail = 1'b0;  fail_code = 3'd0;
    unique case (state_q)
      StIdle: if (start) begin
        x_d = x;  count_d = token_count;  idx_d = '0;  sp_d = '0;
        done_d = 1'b0;  error_d = 1'b0;  busy_d = 1'b1;
        state_d = (token_count == '0) ? StFinish : StFetch;
      end
      StFetch: state_d = (idx_q == count_q) ? StFinish : StWait;
      StWait: if (queue_rd_valid) begin
        tok_d = queue_rd_data;
        state_d = StDispatch;
      end
      StDispatch: begin
        if (!tok_q[NW]) begin
          push_d = tok_q[NW-1:0];  state_d = StPush;
        end else if (op == OpVar) begin
          push_d = x_q;  state_d = StPush;
        end else if (op == OpBad5 || op == OpBad7) begin
          fail = 1'b1;  fail_code = 3'd5;
        end else if (sp_q < SW'(2)) begin
          fail = 1'b1;  fail_code = 3'd1;
        end else begin
          b_d = top_v;  a_d = sec_v;  acc_d = sec_v;  sp_d = sp_q - SW'(2);
          quo_d = {mag(sec_v), {FW{1'b0}}};  rem_d = '0;
          cnt_d = (op == OpPow) ? NW'(1) : '0;
          state_d = StExec;
        end
      end
      StPush: begin
        if (sp_q == SW'(STACK_SIZE)) begin
          fail = 1'b1;  fail_code = 3'd2;
        end else begin
          stack_d[sp_q[SW-2:0]] = push_q;
          sp_d = sp_q + SW'(1);  idx_d = idx_q + CW'(1);  state_d = StFetch;
        end
      end
      StExec: begin
        case (op)
          OpPlus: begin push_d = fit(ext(a_q) + ext(b_q));  state_d = StPush; end
          OpSub:  begin push_d = fit(ext(a_q) - ext(b_q));  state_d = StPush; end
          OpMul:  begin push_d = qmul(a_q, b_q);            state_d = StPush; end
          OpDiv: begin
            if (b_q == '0) begin
              fail = 1'b1;  fail_code = 3'd3;
            end else begin
              rem_d = ge ? rem_sh - dvs : rem_sh;
              quo_d = quo_nx;
              cnt_d = cnt_q + NW'(1);
              if (cnt_q == NW'(QW - 1)) begin
                push_d  = fit((a_q[NW-1] ^ b_q[NW-1]) ? -quo_s : quo_s);
                state_d = StPush;
              end
            end
          end
          OpPow: begin
            if (pow_n[NW-1]) begin
              fail = 1'b1;  fail_code = 3'd4;
            end else if (pow_n == '0) begin
              push_d = NW'(1) << FW;  state_d = StPush;
            end else if (cnt_q == pow_n) begin
              push_d = acc_q;  state_d = StPush;
            end else begin
              acc_d = qmul(acc_q, a_q);  cnt_d = cnt_q + NW'(1);
            end
          end
          default: state_d = StError;
        endcase
      end
      StFinish: begin
        if (sp_q == SW'(1)) begin
          result_d = stack_q[0];  done_d = 1'b1;  busy_d = 1'b0;  state_d = StIdle;
        end else begin
          fail = 1'b1;  fail_code = 3'd6;
        end
      end
      StError: begin
        result_d = '0;  error_d = 1'b1;  done_d = 1'b1;  busy_d = 1'b0;  state_d = StIdle;
      end
    endcase
    if (fail) begin
      error_code_d = fail_code;
      state_d = StError;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;  x_q <= '0;  a_q <= '0;  b_q <= '0;  acc_q <= '0;  push_q <= '0;
      cnt_q <= '0;  result_q <= '0;  count_q <= '0;  idx_q <= '0;  sp_q <= '0;
      stack_q <= '{default: '0};  tok_q <= '0;  quo_q <= '0;  rem_q <= '0;
      busy_q <= 1'b0;  done_q <= 1'b0;  error_q <= 1'b0;  error_code_q <= '0;
    end else begin
      state_q <= state_d;  x_q <= x_d;  a_q <= a_d;  b_q <= b_d;  acc_q <= acc_d;
      push_q <= push_d;  cnt_q <= cnt_d;  result_q <= result_d;  count_q <= count_d;
      idx_q <= idx_d;  sp_q <= sp_d;  stack_q <= stack_d;  tok_q <= tok_d;
      quo_q <= quo_d;  rem_q <= rem_d;  busy_q <= busy_d;  done_q <= done_d;
      error_q <= error_d;  error_code_q <= error_code_d;
    end
  end

  assign queue_rd_en    = (state_q == StFetch) && (idx_q != count_q);
  assign queue_rd_index = idx_q[IW-1:0];
  assign busy           = busy_q;
  assign done           = done_q;
  assign result         = result_q;
  assign error          = error_q;
  assign error_code     = error_code_q;

endmodule

// File: tb/tb_rpn_evaluator.sv
// Directed bench for rpn_evaluator: behavioural token queue with adjustable read latency.
module tb_rpn_evaluator;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] x = '0;
  logic [6:0]  token_count = '0;
  logic        queue_rd_en;
  logic [5:0]  queue_rd_index;
  logic [16:0] queue_rd_data = '0;
  logic        queue_rd_valid = 1'b0;
  logic        busy, done, error;
  logic [15:0] result;
  logic [2:0]  error_code;

  int          checks = 0, errors = 0, lat = 1;
  logic [16:0] toks [64];
  logic [5:0]  rd_i;

  rpn_evaluator dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .x              (x),
    .token_count    (token_count),
    .queue_rd_en    (queue_rd_en),
    .queue_rd_index (queue_rd_index),
    .queue_rd_data  (queue_rd_data),
    .queue_rd_valid (queue_rd_valid),
    .busy           (busy),
    .done           (done),
    .result         (result),
    .error          (error),
    .error_code     (error_code)
  );

  always #5 clk = ~clk;

  // Queue model: answer each strobe `lat` cycles later with a one-cycle valid.
  initial forever begin
    @(posedge clk);
    #1;
    if (rst_n && queue_rd_en) begin
      rd_i = queue_rd_index;
      repeat (lat) @(posedge clk);
      #1;
      queue_rd_valid = 1'b1;
      queue_rd_data  = toks[rd_i];
      @(posedge clk);
      #1;
      queue_rd_valid = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load3(input logic [16:0] t0, input logic [16:0] t1, input logic [16:0] t2);
    toks[0] = t0;
    toks[1] = t1;
    toks[2] = t2;
  endtask

  task automatic run_eval(input string tag, input int n, input logic [15:0] xv, input int l);
    int cyc;
    lat = l;
    @(posedge clk);
    #1;
    start = 1'b1;
    token_count = n[6:0];
    x = xv;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic expect_ok(input string tag, input logic [15:0] exp);
    check_eq({tag, "_result"}, {16'd0, result}, {16'd0, exp});
    check_eq({tag, "_error"}, {31'd0, error}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic expect_err(input string tag, input logic [2:0] code);
    check_eq({tag, "_error"}, {31'd0, error}, 32'd1);
    check_eq({tag, "_code"}, {29'd0, error_code}, {29'd0, code});
    check_eq({tag, "_result"}, {16'd0, result}, 32'd0);
  endtask

  initial begin
    logic [15:0] sum_exp;
`ifdef RPN_EVALUATOR_SATURATE_EN
    sum_exp = 16'h7FFF;
`else
    sum_exp = 16'hC800;
`endif
    for (int i = 0; i < 64; i++) toks[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_error", {31'd0, error}, 32'd0);
    check_eq("rst_result", {16'd0, result}, 32'd0);
    check_eq("rst_code", {29'd0, error_code}, 32'd0);
    check_eq("rst_rd_en", {31'd0, queue_rd_en}, 32'd0);
    rst_n = 1'b1;

    load3(17'h00200, 17'h00300, 17'h10000);
    run_eval("add", 3, 16'h0000, 1);
    expect_ok("add", 16'h0500);

    load3(17'h00200, 17'h00300, 17'h10001);
    run_eval("sub", 3, 16'h0000, 1);
    expect_ok("sub", 16'hFF00);

    load3(17'h10006, 17'h10006, 17'h10002);
    run_eval("sq", 3, 16'h0180, 1);
    expect_ok("sq", 16'h0240);

    load3(17'h00700, 17'h00200, 17'h10003);
    run_eval("div_l1", 3, 16'h0000, 1);
    expect_ok("div_l1", 16'h0380);
    run_eval("div_l5", 3, 16'h0000, 5);
    expect_ok("div_l5", 16'h0380);

    load3(17'h0F900, 17'h00200, 17'h10003);
    run_eval("div_neg", 3, 16'h0000, 1);
    expect_ok("div_neg", 16'hFC80);

    load3(17'h0FF00, 17'h00300, 17'h10003);
    run_eval("div_trunc", 3, 16'h0000, 2);
    expect_ok("div_trunc", 16'hFFAB);

    load3(17'h00100, 17'h00000, 17'h10003);
    run_eval("div0", 3, 16'h0000, 1);
    expect_err("div0", 3'd3);

    load3(17'h10006, 17'h00300, 17'h10004);
    run_eval("pow3", 3, 16'hFE00, 1);
    expect_ok("pow3", 16'hF800);

    load3(17'h00500, 17'h00000, 17'h10004);
    run_eval("pow0", 3, 16'h0000, 1);
    expect_ok("pow0", 16'h0100);

    load3(17'h00200, 17'h0FF00, 17'h10004);
    run_eval("pow_neg", 3, 16'h0000, 1);
    expect_err("pow_neg", 3'd4);

    load3(17'h10000, 17'h00000, 17'h00000);
    run_eval("under", 1, 16'h0000, 1);
    expect_err("under", 3'd1);
    load3(17'h00500, 17'h00000, 17'h00000);
    run_eval("recover", 1, 16'h0000, 1);
    expect_ok("recover", 16'h0500);

    load3(17'h10005, 17'h00000, 17'h00000);
    run_eval("badop", 1, 16'h0000, 1);
    expect_err("badop", 3'd5);

    run_eval("empty", 0, 16'h0000, 1);
    expect_err("empty", 3'd6);

    load3(17'h00200, 17'h00300, 17'h00000);
    run_eval("depth2", 2, 16'h0000, 1);
    expect_err("depth2", 3'd6);

    for (int i = 0; i < 17; i++) toks[i] = 17'h00100;
    run_eval("ovf", 17, 16'h0000, 1);
    expect_err("ovf", 3'd2);

    load3(17'h06400, 17'h06400, 17'h10000);
    run_eval("sum200", 3, 16'h0000, 1);
    expect_ok("sum200", sum_exp);

    // Abort a divide partway through with an asynchronous reset.
    load3(17'h00700, 17'h00200, 17'h10003);
    @(posedge clk);
    #1;
    start = 1'b1;
    token_count = 7'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    check_eq("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_done", {31'd0, done}, 32'd0);
    check_eq("abort_result", {16'd0, result}, 32'd0);
    check_eq("abort_rd_en", {31'd0, queue_rd_en}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    load3(17'h00200, 17'h00300, 17'h10000);
    run_eval("post_rst", 3, 16'h0000, 1);
    expect_ok("post_rst", 16'h0500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rpn_evaluator.md
Name: rpn_evaluator

Overview:
- Downstream consumer of the infix-to-postfix parser's output queue.
- Walks the postfix token list for one abscissa value `x` and computes f(x) in signed Q8.8 using an internal operand stack.
- One evaluation per `start` pulse; the plot stage sweeps `x` and issues one `start` per column.

Parameters:
- INTEGER_PART_WIDTH, 8, integer bits of a number
- FRACTIONAL_PART_WIDTH, 8, fraction bits of a number
- NUMBER_WIDTH, INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH, operand width, two's complement
- TOKEN_WIDTH, NUMBER_WIDTH+1, queue entry width
- OUTPUT_QUEUE_SIZE, 64, depth of the token queue
- STACK_SIZE, 16, operand stack depth

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin evaluation; ignored while busy
- x  in  NUMBER_WIDTH  variable value, sampled on accepted start
- token_count  in  $clog2(OUTPUT_QUEUE_SIZE)+1  number of tokens, sampled on start
- queue_rd_en  out  1  one-cycle read strobe
- queue_rd_index  out  $clog2(OUTPUT_QUEUE_SIZE)  token index, valid with strobe
- queue_rd_data  in  TOKEN_WIDTH  token: MSB=1 operator (low 3 bits opcode), MSB=0 number
- queue_rd_valid  in  1  queue_rd_data valid; arrives >=1 cycle after strobe
- busy  out  1  evaluation in progress
- done  out  1  high from completion until next accepted start
- result  out  NUMBER_WIDTH  f(x); 0 on error
- error  out  1  evaluation failed
- error_code  out  3  1 underflow, 2 stack overflow, 3 div by zero, 4 negative exponent, 5 bad opcode, 6 final depth != 1

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, error, queue_rd_en = 0; result, error_code, queue_rd_index, stack pointer = 0. Reset mid-evaluation aborts immediately; no partial result is kept.
- Opcodes:
  - 0 PLUS, 1 SUB, 2 MUL, 3 DIV, 4 POW, 6 VAR.
  - 5 and 7 are errors with code 5.
- IDLE:
  - On start: latch x and token_count; clear index, stack pointer, done, error; set busy.
  - token_count=0 -> FINISH, which reports code 6.
- FETCH:
  - Pulse queue_rd_en with the current index, then go to WAIT.
  - If index==token_count, go to FINISH instead.
- WAIT: hold until queue_rd_valid, latch the token, go to DISPATCH.
- DISPATCH:
  - Number -> PUSH.
  - VAR -> push latched x.
  - Binary operator: depth<2 -> ERROR (code 1); otherwise pop b (top) then a, go to EXEC.
- Overflow check: a push at depth STACK_SIZE -> ERROR (code 2).
- EXEC (all results pushed, then index+1 and back to FETCH):
  - PLUS/SUB: single cycle, a±b.
  - MUL: single cycle. Form the 2*NUMBER_WIDTH signed product, arithmetic shift right by FRACTIONAL_PART_WIDTH, keep the low NUMBER_WIDTH bits.
  - DIV:
    - b==0 -> ERROR (code 3).
    - Otherwise restoring division of |a|<<FRACTIONAL_PART_WIDTH by |b|, one quotient bit per cycle: NUMBER_WIDTH+FRACTIONAL_PART_WIDTH cycles.
    - Sign applied at the end; truncation toward zero.
  - POW:
    - Exponent n = b>>>FRACTIONAL_PART_WIDTH (integer part, fraction dropped).
    - n<0 -> ERROR (code 4).
    - n==0 -> push 1.0 (1<<FRACTIONAL_PART_WIDTH).
    - Otherwise acc=a, then n-1 Q-multiplies, one per cycle.
- Per-token latency: FETCH 1 + queue latency + DISPATCH 1 + EXEC (1 / 24 / n) + PUSH 1.
- FINISH:
  - Depth==1 -> result = top, done=1, busy=0.
  - Otherwise ERROR (code 6).
- ERROR: result=0, error=1, done=1, busy=0; return to IDLE. done/error hold until the next start.
- A start arriving in the same cycle as completion is ignored.
- queue_rd_valid is ignored outside WAIT.

Optional Feature:
- Macro: RPN_EVALUATOR_SATURATE_EN.
- When defined:
  - PLUS, SUB and MUL results (and every POW step) clamp to 0x7FFF / 0x8000 on overflow.
  - The DIV quotient clamps likewise.
- When undefined: results wrap modulo 2^NUMBER_WIDTH.
- No error code is raised in either case.

Test Plan:
- Tokens 0x00200, 0x00300, 0x10000 (2 3 +), count 3 -> result 0x0500, error 0, done high, busy low.
- x=0x0180; tokens 0x10006, 0x10006, 0x10002 (x x *) -> 0x0240 (2.25).
- Tokens 0x00700, 0x00200, 0x10003 (7/2) -> 0x0380 after the multi-cycle divide. Tokens 0x00100, 0x00000, 0x10003 -> error_code 3, result 0.
- x=0xFE00; tokens 0x10006, 0x00300, 0x10004 (x**3) -> 0xF800 (-8). Exponent 0xFF00 -> error_code 4.
- Single token 0x10000 -> error_code 1. A following start with token 0x00500 -> result 0x0500, error 0. Queue latency of 1 and 5 cycles gives identical results.
- Tokens 0x06400, 0x06400, 0x10000 (100+100):
  - Macro defined -> 0x7FFF.
  - Macro undefined -> 0xC800.
  - Assert rst_n low mid-divide -> all outputs 0 immediately.
